kbd_voice_alloc: RTL and testbench
==================================

Name: kbd_voice_alloc

Overview:
- Polyphonic voice scheduler between the PS/2 packet decoder and the oscillator bank.
- Takes decoded make/break scancode events and maps note keys to semitone numbers. Handles octave-shift keys.
- Shares NV oscillator voices among pressed keys: lowest free voice first, round-robin stealing when all voices are busy.
- Drives per-voice gate and note to the synth voices.

Parameters:
- NV, 4, number of oscillator voices (2..8).
- OCT_RST, 4, octave value after reset (0..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- code_valid  in  1  one-cycle strobe, a complete packet is available.
- code  in  8  set-2 scancode (F0 prefix already stripped by the decoder).
- code_break  in  1  1 = key release, 0 = key press; qualified by code_valid.
- voice_gate  out  NV  per-voice gate, 1 = sounding.
- voice_note  out  7*NV  per-voice note, voice i at [7i+6:7i]; note = octave*12 + semitone.
- octave  out  3  current octave.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Reset (reset==0 at posedge clk):
  - voice_gate=0, all voice_note=0, octave=OCT_RST, overflow=0, busy=0.
  - Skid buffer emptied; steal_ptr=0; FSM to IDLE.
  - Reset applied mid-operation discards any in-flight event.
- Key map, combinational, code to semitone:
  - 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5, 2C->6, 34->7, 35->8, 33->9, 3C->10, 3B->11, 42->12.
  - 1A = octave down, 22 = octave up.
  - All other codes are ignored: the FSM still runs, with no effect.
- Input capture:
  - In IDLE with the skid buffer empty, an event is taken directly.
  - Otherwise the event goes into a one-entry skid buffer {code, code_break}.
  - If the skid buffer is full, the event is dropped and overflow is set (sticky until reset).
  - In IDLE with the skid buffer full, the skid entry is taken first. A simultaneous new event then refills the skid buffer.
- FSM states: IDLE -> DECODE -> SCAN -> APPLY -> IDLE. Exactly one cycle per state; busy=1 outside IDLE.
- DECODE:
  - Latches the semitone and key class.
  - Octave keys: act on press only (release ignored), saturate at 0 and 7, go DECODE -> IDLE directly.
  - Unmapped keys: go DECODE -> IDLE.
  - Octave changes never alter notes already sounding.
- SCAN, combinational over voices:
  - match = lowest i with gate[i]==1 and note[i]==target, where target = octave*12 + semitone.
  - free = lowest i with gate[i]==0.
- APPLY, press:
  - If match exists: no change; a key held twice is never duplicated.
  - Else if free exists: that voice gets gate=1, note=target.
  - Else: voice steal_ptr gets note=target, gate stays 1, and steal_ptr increments modulo NV.
- APPLY, release:
  - If match exists: gate[match]=0 and the note is held unchanged.
  - Else: no change. This covers releases of stolen notes and releases after an octave change.
- Latency: event accepted at edge N (IDLE) -> voice outputs update at edge N+3. Back-to-back events are sustained at 1 per 4 cycles via the skid buffer.
- Release matching uses the current octave. A note pressed before an octave change is therefore released only by reset or by re-pressing and releasing it in the original octave.

Test Plan:
- Reset, then press 1C: code_valid pulse, code=1C, code_break=0 -> 3 cycles later voice_gate=0001, voice_note[6:0]=48, busy high exactly 3 cycles.
- Press 1C, 24, 34, 42 then release 24 -> gates 1111 with notes 48/51/55/60; after the release voice_gate=1101 and voice 1 note stays 51.
- NV=4 all busy, press 1D then 1B -> voice 0 note=49, then voice 1 note=50, steal_ptr=2, gates stay 1111.
- Press 22 three times, then 1A once, then press 1C -> octave 7 (saturated from 4 via 5, 6, 7), then 6; 1C gives note 72. Also check 1A repeated at 0 stays 0.
- Three code_valid pulses on consecutive cycles from IDLE -> first two processed in order, third dropped, overflow=1 and held until reset.
- Assert reset (low) for 1 cycle during SCAN with three voices gated -> next cycle all outputs at reset values and the pending event is lost; press 1C afterwards -> voice 0 = 48.

Source files
------------

// File: rtl/kbd_voice_alloc.sv
// Polyphonic voice scheduler. Maps PS/2 make/break scancodes to notes and
// shares NV oscillator voices: lowest free voice first, round-robin stealing when full.
module kbd_voice_alloc #(
    parameter int NV      = 4,
    parameter int OCT_RST = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            code_valid,
    input  logic [7:0]      code,
    input  logic            code_break,
    output logic [NV-1:0]   voice_gate,
    output logic [7*NV-1:0] voice_note,
    output logic [2:0]      octave,
    output logic            busy,
    output logic            overflow
);

    localparam int IW = (NV > 1) ? $clog2(NV) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, SCAN, APPLY} state_t;
    typedef enum logic [1:0] {K_NOTE, K_OCT_UP, K_OCT_DN, K_NONE} key_t;

    state_t        state;
    logic [7:0]    cur_code;
    logic          cur_brk;
    logic [7:0]    skid_code;
    logic          skid_brk;
    logic          skid_full;
    logic [3:0]    semi;
    logic [6:0]    tgt_q;
    logic          match_found, free_found;
    logic [IW-1:0] match_idx, free_idx, steal_ptr;
    logic [6:0]    notes [NV];

    // Key map: combinational decode of the event currently being processed
    key_t       dec_class;
    logic [3:0] dec_semi;

    always_comb begin
        dec_class = K_NOTE;
        dec_semi  = 4'd0;
        case (cur_code)
            8'h1C: dec_semi = 4'd0;
            8'h1D: dec_semi = 4'd1;
            8'h1B: dec_semi = 4'd2;
            8'h24: dec_semi = 4'd3;
            8'h23: dec_semi = 4'd4;
            8'h2B: dec_semi = 4'd5;
            8'h2C: dec_semi = 4'd6;
            8'h34: dec_semi = 4'd7;
            8'h35: dec_semi = 4'd8;
            8'h33: dec_semi = 4'd9;
            8'h3C: dec_semi = 4'd10;
            8'h3B: dec_semi = 4'd11;
            8'h42: dec_semi = 4'd12;
            8'h1A: dec_class = K_OCT_DN;
            8'h22: dec_class = K_OCT_UP;
            default: dec_class = K_NONE;
        endcase
    end

    // target = octave*12 + semitone, at most 7*12+12 = 96
    logic [6:0] oct_base, target;
    assign oct_base = ({4'b0, octave} << 3) + ({4'b0, octave} << 2);
    assign target   = oct_base + {3'b0, semi};

    logic          scan_match_found, scan_free_found;
    logic [IW-1:0] scan_match_idx, scan_free_idx;

    // Walk from the top down so the lowest qualifying index wins
    always_comb begin
        scan_match_found = 1'b0;
        scan_match_idx   = '0;
        scan_free_found  = 1'b0;
        scan_free_idx    = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (voice_gate[i] && notes[i] == target) begin
                scan_match_found = 1'b1;
                scan_match_idx   = IW'(i);
            end
            if (!voice_gate[i]) begin
                scan_free_found = 1'b1;
                scan_free_idx   = IW'(i);
            end
        end
    end

    for (genvar g = 0; g < NV; g++) begin : g_note_out
        assign voice_note[7*g +: 7] = notes[g];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cur_code    <= 8'h00;
            cur_brk     <= 1'b0;
            skid_code   <= 8'h00;
            skid_brk    <= 1'b0;
            skid_full   <= 1'b0;
            semi        <= 4'd0;
            tgt_q       <= 7'd0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            steal_ptr   <= '0;
            voice_gate  <= '0;
            octave      <= 3'(OCT_RST);
            overflow    <= 1'b0;
            // NOTE: the note array is a handful of flops, so it is reset like any other register.
            for (int i = 0; i < NV; i++) notes[i] <= 7'd0;
        end else begin
            if (state != IDLE && code_valid) begin
                if (skid_full) overflow <= 1'b1;
                else begin
                    skid_code <= code;
                    skid_brk  <= code_break;
                    skid_full <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // A buffered event is older than a new one, so it goes first
                    if (skid_full) begin
                        cur_code  <= skid_code;
                        cur_brk   <= skid_brk;
                        state     <= DECODE;
                        skid_full <= code_valid;
                        skid_code <= code;
                        skid_brk  <= code_break;
                    end else if (code_valid) begin
                        cur_code <= code;
                        cur_brk  <= code_break;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    semi <= dec_semi;
                    case (dec_class)
                        K_NOTE:   state <= SCAN;
                        K_OCT_UP: begin
                            if (!cur_brk && octave != 3'd7) octave <= octave + 3'd1;
                            state <= IDLE;
                        end
                        K_OCT_DN: begin
                            if (!cur_brk && octave != 3'd0) octave <= octave - 3'd1;
                            state <= IDLE;
                        end
                        default:  state <= IDLE;
                    endcase
                end
                SCAN: begin
                    match_found <= scan_match_found;
                    match_idx   <= scan_match_idx;
                    free_found  <= scan_free_found;
                    free_idx    <= scan_free_idx;
                    tgt_q       <= target;
                    state       <= APPLY;
                end
                APPLY: begin
                    if (!cur_brk) begin
                        if (!match_found) begin
                            if (free_found) begin
                                voice_gate[free_idx] <= 1'b1;
                                notes[free_idx]      <= tgt_q;
                            end else begin
                                notes[steal_ptr] <= tgt_q;
                                steal_ptr <= (steal_ptr == IW'(NV - 1)) ? '0 : steal_ptr + 1'b1;
                            end
                        end
                    end else if (match_found) begin
                        voice_gate[match_idx] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_voice_alloc.sv
// Directed bench for kbd_voice_alloc (NV=4, OCT_RST=4) with hand-computed expectations.
module tb_kbd_voice_alloc;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            code_valid;
    logic [7:0]      code;
    logic            code_break;
    logic [NV-1:0]   voice_gate;
    logic [7*NV-1:0] voice_note;
    logic [2:0]      octave;
    logic            busy;
    logic            overflow;

    int n_vec = 0;
    int n_err = 0;

    kbd_voice_alloc #(.NV(NV), .OCT_RST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .code_break (code_break),
        .voice_gate (voice_gate),
        .voice_note (voice_note),
        .octave     (octave),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse one event at a falling edge, then let the FSM finish
    task automatic send(input logic [7:0] c, input logic brk);
        @(negedge clk);
        code_valid = 1'b1;
        code       = c;
        code_break = brk;
        @(negedge clk);
        code_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_event", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic int unsigned note_of(input int i);
        return int'(voice_note[7*i +: 7]);
    endfunction

    initial begin
        reset      = 1'b0;
        code_valid = 1'b0;
        code       = 8'h00;
        code_break = 1'b0;
        do_reset();

        check("rst_gate", voice_gate, 0);
        check("rst_notes", voice_note, 0);
        check("rst_octave", octave, 4);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);

        // Single press: busy for exactly DECODE/SCAN/APPLY, gate appears after APPLY
        @(negedge clk);
        code_valid = 1'b1; code = 8'h1C; code_break = 1'b0;
        @(negedge clk);
        code_valid = 1'b0;
        check("p1_busy_decode", busy, 1);
        @(negedge clk);
        check("p1_busy_scan", busy, 1);
        @(negedge clk);
        check("p1_busy_apply", busy, 1);
        check("p1_gate_before", voice_gate, 0);
        @(negedge clk);
        check("p1_busy_done", busy, 0);
        check("p1_gate", voice_gate, 4'b0001);
        check("p1_note0", note_of(0), 48);

        // Fill all voices, then release the second one
        send(8'h24, 1'b0);
        send(8'h34, 1'b0);
        send(8'h42, 1'b0);
        check("fill_gate", voice_gate, 4'b1111);
        check("fill_notes", voice_note, {7'd60, 7'd55, 7'd51, 7'd48});
        send(8'h1C, 1'b0);
        check("dup_press_gate", voice_gate, 4'b1111);
        check("dup_press_notes", voice_note, {7'd60, 7'd55, 7'd51, 7'd48});
        send(8'h24, 1'b1);
        check("rel_gate", voice_gate, 4'b1101);
        check("rel_note1_held", note_of(1), 51);
        send(8'h23, 1'b1);
        check("rel_unmatched", voice_gate, 4'b1101);

        // Round-robin stealing
        do_reset();
        send(8'h1C, 1'b0);
        send(8'h24, 1'b0);
        send(8'h34, 1'b0);
        send(8'h42, 1'b0);
        send(8'h1D, 1'b0);
        check("steal0_note", note_of(0), 49);
        check("steal0_gate", voice_gate, 4'b1111);
        send(8'h1B, 1'b0);
        check("steal1_note", note_of(1), 50);
        send(8'h2B, 1'b0);
        check("steal2_note", note_of(2), 53);
        check("steal_gates", voice_gate, 4'b1111);
        check("steal_notes", voice_note, {7'd60, 7'd53, 7'd50, 7'd49});

        // Octave keys and saturation
        do_reset();
        send(8'h22, 1'b0);
        check("oct_up1", octave, 5);
        send(8'h22, 1'b0);
        check("oct_up2", octave, 6);
        send(8'h22, 1'b0);
        check("oct_up3", octave, 7);
        send(8'h22, 1'b0);
        check("oct_sat7", octave, 7);
        send(8'h1A, 1'b1);
        check("oct_release_ignored", octave, 7);
        send(8'h1A, 1'b0);
        check("oct_down", octave, 6);
        send(8'h1C, 1'b0);
        check("oct_note", note_of(0), 72);
        for (int i = 0; i < 6; i++) send(8'h1A, 1'b0);
        check("oct_zero", octave, 0);
        send(8'h1A, 1'b0);
        check("oct_sat0", octave, 0);
        check("oct_note_kept", note_of(0), 72);
        send(8'h55, 1'b0);
        check("unmapped_gate", voice_gate, 4'b0001);

        // Three back-to-back events: two processed, third dropped
        do_reset();
        @(negedge clk);
        code_valid = 1'b1; code = 8'h1C; code_break = 1'b0;
        @(negedge clk);
        code = 8'h24;
        @(negedge clk);
        code = 8'h34;
        @(negedge clk);
        code_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("burst_idle", busy, 0);
        check("burst_gate", voice_gate, 4'b0011);
        check("burst_notes", voice_note, {7'd0, 7'd0, 7'd51, 7'd48});
        check("burst_ovf", overflow, 1);
        send(8'h23, 1'b0);
        check("ovf_sticky", overflow, 1);
        check("after_burst_note2", note_of(2), 52);
        do_reset();
        check("ovf_cleared", overflow, 0);

        // Reset during SCAN discards the in-flight event
        send(8'h1C, 1'b0);
        send(8'h24, 1'b0);
        send(8'h34, 1'b0);
        check("pre_rst_gate", voice_gate, 4'b0111);
        send(8'h22, 1'b0);
        @(negedge clk);
        code_valid = 1'b1; code = 8'h2B; code_break = 1'b0;
        @(negedge clk);
        code_valid = 1'b0;
        @(negedge clk);
        check("mid_in_scan", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_gate", voice_gate, 0);
        check("mid_rst_notes", voice_note, 0);
        check("mid_rst_octave", octave, 4);
        check("mid_rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("mid_rst_lost", voice_gate, 0);
        send(8'h1C, 1'b0);
        check("post_rst_gate", voice_gate, 4'b0001);
        check("post_rst_note", note_of(0), 48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
